// File: rtl/param_rom_arbiter.sv
// param_rom_arbiter
// Shares one synchronous parameter ROM read port among N_REQ compute stages.
// A stage requests a burst (base address, length). Requesters are picked
// round-robin, and the owner keeps the grant for its whole burst. Every word
// returned by the ROM is tagged with its owner id and its element index.
// The (valid, id, index) tags travel in a ROM_LAT-deep pipeline so that they
// line up with rom_data.
module param_rom_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int LEN_W   = 9,
    parameter int ROM_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*ADDR_W-1:0]  req_base,
    input  logic [N_REQ*LEN_W-1:0]   req_len,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         done,
    output logic                     rom_en,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [DATA_W-1:0]        rom_data,
    output logic                     rd_valid,
    output logic [$clog2(N_REQ)-1:0] rd_id,
    output logic [LEN_W-1:0]         rd_index,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     busy
);
    localparam int                ID_W     = $clog2(N_REQ);
    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0]  LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ID_W-1:0]   ID_ONE   = ID_W'(1);
    localparam logic [ID_W-1:0]   ID_LAST  = ID_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state_r, state_s;

    logic [N_REQ-1:0]  gnt_r, gnt_s;
    logic [N_REQ-1:0]  done_r, done_s;
    logic              rom_en_r, rom_en_s;
    logic              busy_r, busy_s;
    logic [ADDR_W-1:0] rom_addr_r, rom_addr_s;
    logic [LEN_W-1:0]  cnt_r, cnt_s;
    logic [LEN_W-1:0]  len_r, len_s;
    logic [ID_W-1:0]   owner_r, owner_s;
    logic [ID_W-1:0]   ptr_r, ptr_s;

    logic              sel_found_s;
    logic [ID_W-1:0]   sel_id_s;
    logic [ADDR_W-1:0] sel_base_s;
    logic [LEN_W-1:0]  sel_len_s;

    logic              last_issue_s;
    logic              len_zero_s;
    logic              last_hit_s;

    // Tag pipeline: stage i register, plus the value that feeds each stage.
    logic              pv_r  [0:ROM_LAT-1];
    logic [ID_W-1:0]   pid_r [0:ROM_LAT-1];
    logic [LEN_W-1:0]  pix_r [0:ROM_LAT-1];
    logic              v_s   [0:ROM_LAT-1];
    logic [ID_W-1:0]   id_s  [0:ROM_LAT-1];
    logic [LEN_W-1:0]  ix_s  [0:ROM_LAT-1];

    // Round-robin pick: first asserted request at or above the pointer, with wrap.
    always_comb begin
        int cand;
        sel_found_s = 1'b0;
        sel_id_s    = {ID_W{1'b0}};
        sel_base_s  = {ADDR_W{1'b0}};
        sel_len_s   = LEN_ZERO;
        cand        = 0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = (int'(ptr_r) + i) % N_REQ;
            if (!sel_found_s && req[cand]) begin
                sel_found_s = 1'b1;
                sel_id_s    = ID_W'(cand);
                sel_base_s  = req_base[cand*ADDR_W +: ADDR_W];
                sel_len_s   = req_len[cand*LEN_W +: LEN_W];
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Stage inputs: stage 0 takes the issue that is live now, and each later stage takes the one before it.
    always_comb begin
        v_s[0]  = rom_en_r;
        id_s[0] = owner_r;
        ix_s[0] = cnt_r;
        for (int i = 1; i < ROM_LAT; i++) begin
            v_s[i]  = pv_r[i-1];
            id_s[i] = pid_r[i-1];
            ix_s[i] = pix_r[i-1];
        end
    end

    // Burst progress flags; last_hit_s means the final element reaches the pipeline output at the next edge.
    always_comb begin
        last_issue_s = ((cnt_r + LEN_ONE) == len_r);
        len_zero_s   = (len_r == LEN_ZERO);
        last_hit_s   = v_s[ROM_LAT-1] && (ix_s[ROM_LAT-1] == (len_r - LEN_ONE));
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (sel_found_s) begin
                    if (sel_len_s == LEN_ZERO) begin
                        state_s = DRAIN;
                    end else begin
                        state_s = ISSUE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (last_issue_s) begin
                    state_s = DRAIN;
                end else begin
                    state_s = ISSUE;
                end
            end
            DRAIN: begin
                if (|done_r) begin
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Output logic: next value of every registered output and of the burst bookkeeping.
    always_comb begin
        gnt_s      = gnt_r;
        done_s     = {N_REQ{1'b0}};
        rom_en_s   = rom_en_r;
        busy_s     = busy_r;
        rom_addr_s = rom_addr_r;
        cnt_s      = cnt_r;
        len_s      = len_r;
        owner_s    = owner_r;
        ptr_s      = ptr_r;
        case (state_r)
            IDLE: begin
                if (sel_found_s) begin
                    gnt_s      = N_REQ'(1) << sel_id_s;
                    owner_s    = sel_id_s;
                    len_s      = sel_len_s;
                    rom_addr_s = sel_base_s;
                    cnt_s      = LEN_ZERO;
                    rom_en_s   = (sel_len_s != LEN_ZERO);
                    busy_s     = 1'b1;
                end else begin
                    gnt_s    = {N_REQ{1'b0}};
                    rom_en_s = 1'b0;
                    busy_s   = 1'b0;
                end
            end
            ISSUE: begin
                cnt_s      = cnt_r + LEN_ONE;
                rom_addr_s = rom_addr_r + ADDR_ONE;
                done_s     = gnt_r & {N_REQ{last_hit_s}};
                if (last_issue_s) begin
                    rom_en_s = 1'b0;
                end else begin
                    rom_en_s = 1'b1;
                end
            end
            DRAIN: begin
                rom_en_s = 1'b0;
                if (|done_r) begin
                    gnt_s  = {N_REQ{1'b0}};
                    busy_s = 1'b0;
                    if (owner_r == ID_LAST) begin
                        ptr_s = {ID_W{1'b0}};
                    end else begin
                        ptr_s = owner_r + ID_ONE;
                    end
                end else if (len_zero_s) begin
                    // An empty burst has no data to wait for: done follows the grant by one cycle.
                    done_s = gnt_r;
                end else begin
                    done_s = gnt_r & {N_REQ{last_hit_s}};
                end
            end
            default: begin
                gnt_s    = {N_REQ{1'b0}};
                rom_en_s = 1'b0;
                busy_s   = 1'b0;
            end
        endcase
    end

    // Registered outputs and burst bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_r      <= {N_REQ{1'b0}};
            done_r     <= {N_REQ{1'b0}};
            rom_en_r   <= 1'b0;
            busy_r     <= 1'b0;
            rom_addr_r <= {ADDR_W{1'b0}};
            cnt_r      <= LEN_ZERO;
            len_r      <= LEN_ZERO;
            owner_r    <= {ID_W{1'b0}};
            ptr_r      <= {ID_W{1'b0}};
        end else begin
            gnt_r      <= gnt_s;
            done_r     <= done_s;
            rom_en_r   <= rom_en_s;
            busy_r     <= busy_s;
            rom_addr_r <= rom_addr_s;
            cnt_r      <= cnt_s;
            len_r      <= len_s;
            owner_r    <= owner_s;
            ptr_r      <= ptr_s;
        end
    end

    // Tag pipeline shift; reset discards anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                pv_r[i]  <= 1'b0;
                pid_r[i] <= {ID_W{1'b0}};
                pix_r[i] <= LEN_ZERO;
            end
        end else begin
            for (int i = 0; i < ROM_LAT; i++) begin
                pv_r[i]  <= v_s[i];
                pid_r[i] <= id_s[i];
                pix_r[i] <= ix_s[i];
            end
        end
    end

    assign gnt      = gnt_r;
    assign done     = done_r;
    assign rom_en   = rom_en_r;
    assign rom_addr = rom_addr_r;
    assign busy     = busy_r;
    assign rd_valid = pv_r[ROM_LAT-1];
    assign rd_id    = pid_r[ROM_LAT-1];
    assign rd_index = pix_r[ROM_LAT-1];
    assign rd_data  = rom_data;

endmodule
